// File: rtl/vga_scanout.sv
// VGA scan-out: H/V timing, fixed-latency frame-buffer fetch, writable palette to RGB; no backpressure.
// Latency fb_req_o -> RGB/de_o/frame_o/syncs is FB_LAT+2 cycles. Optional VGA_TEST_PATTERN_EN adds colour bars.
module vga_scanout #(
   parameter int HD     = 1280,
   parameter int HF     = 48,
   parameter int HR     = 112,
   parameter int HB     = 248,
   parameter int VD     = 1024,
   parameter int VF     = 1,
   parameter int VR     = 3,
   parameter int VB     = 38,
   parameter bit HS_POL = 1'b1,
   parameter bit VS_POL = 1'b1,
   parameter int BPP    = 2,
   parameter int RGB_W  = 12,
   parameter int FB_LAT = 1,
   parameter int X_W    = $clog2(HD),
   parameter int Y_W    = $clog2(VD)
) (
   input  logic             clk,
   input  logic             rst,
`ifdef VGA_TEST_PATTERN_EN
   input  logic             tp_en_i,
`endif
   output logic             fb_req_o,
   output logic [X_W-1:0]   fb_x_o,
   output logic [Y_W-1:0]   fb_y_o,
   input  logic [BPP-1:0]   fb_data_i,
   input  logic             pal_we_i,
   input  logic [BPP-1:0]   pal_addr_i,
   input  logic [RGB_W-1:0] pal_data_i,
   output logic             VGA_HS,
   output logic             VGA_VS,
   output logic             de_o,
   output logic [RGB_W-1:0] RGB,
   output logic             frame_o
);

   localparam int HTOT  = HD + HF + HR + HB;
   localparam int VTOT  = VD + VF + VR + VB;
   localparam int HC_W  = $clog2(HTOT);
   localparam int VC_W  = $clog2(VTOT);
   localparam int H_ACT = HR + HB;
   localparam int V_ACT = VR + VB;
   localparam int PAL_N = 2 ** BPP;
   localparam int DL    = FB_LAT + 2;
   localparam logic [HC_W-1:0] H_LAST = HC_W'(HTOT - 1);
   localparam logic [VC_W-1:0] V_LAST = VC_W'(VTOT - 1);

   logic [HC_W-1:0]  hcnt;
   logic [VC_W-1:0]  vcnt;
   logic [31:0]      h32;
   logic [31:0]      v32;
   logic             act0;
   logic             hs0;
   logic             vs0;
   logic             fr0;
   logic [DL-1:0]    de_pipe;
   logic [DL-1:0]    hs_pipe;
   logic [DL-1:0]    vs_pipe;
   logic [DL-1:0]    fr_pipe;
   logic [BPP-1:0]   idx;
   logic [RGB_W-1:0] pal [PAL_N];
   logic [RGB_W-1:0] pal_q;
   logic [RGB_W-1:0] rgb_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (hcnt == H_LAST) begin
         hcnt <= '0;
         vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VC_W'(1);
      end else begin
         hcnt <= hcnt + HC_W'(1);
      end
   end

   // Compare in 32 bits so region ends that equal 2**HC_W cannot wrap.
   always_comb begin
      h32      = 32'(hcnt);
      v32      = 32'(vcnt);
      act0     = (h32 >= H_ACT) && (h32 < H_ACT + HD) && (v32 >= V_ACT) && (v32 < V_ACT + VD);
      hs0      = h32 < HR;
      vs0      = v32 < VR;
      fr0      = act0 && (h32 == H_ACT) && (v32 == V_ACT);
      fb_req_o = act0;
      fb_x_o   = '0;
      fb_y_o   = '0;
      if (act0) begin
         fb_x_o = X_W'(h32 - 32'(H_ACT));
         fb_y_o = Y_W'(v32 - 32'(V_ACT));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         de_pipe <= '0;
         hs_pipe <= '0;
         vs_pipe <= '0;
         fr_pipe <= '0;
      end else begin
         de_pipe <= {de_pipe[DL-2:0], act0};
         hs_pipe <= {hs_pipe[DL-2:0], hs0};
         vs_pipe <= {vs_pipe[DL-2:0], vs0};
         fr_pipe <= {fr_pipe[DL-2:0], fr0};
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   logic                         tp_act;
   logic [FB_LAT-1:0]            tp_pipe;
   logic [FB_LAT-1:0][BPP-1:0]   bar_pipe;

   // Bar index travels FB_LAT stages so it meets the palette read at the same time as fb_data_i.
   always_ff @(posedge clk) begin
      if (rst) begin
         tp_act   <= 1'b0;
         tp_pipe  <= '0;
         bar_pipe <= '0;
      end else begin
         if (hcnt == '0 && vcnt == '0) begin
            tp_act <= tp_en_i;
         end
         tp_pipe[0]  <= tp_act;
         bar_pipe[0] <= fb_x_o[X_W-1 -: BPP];
         for (int i = 1; i < FB_LAT; i++) begin
            tp_pipe[i]  <= tp_pipe[i-1];
            bar_pipe[i] <= bar_pipe[i-1];
         end
      end
   end

   assign idx = tp_pipe[FB_LAT-1] ? bar_pipe[FB_LAT-1] : fb_data_i;
`else
   assign idx = fb_data_i;
`endif

   // A write and a read of the same entry in one cycle returns the old colour.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PAL_N; i++) begin
            pal[i] <= (i == PAL_N - 1) ? '1 : '0;
         end
         pal_q <= '0;
      end else begin
         if (pal_we_i) begin
            pal[pal_addr_i] <= pal_data_i;
         end
         pal_q <= pal[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_q <= '0;
      end else begin
         rgb_q <= de_pipe[FB_LAT] ? pal_q : '0;
      end
   end

   assign de_o    = de_pipe[DL-1];
   assign frame_o = fr_pipe[DL-1];
   assign VGA_HS  = hs_pipe[DL-1] ? HS_POL : ~HS_POL;
   assign VGA_VS  = vs_pipe[DL-1] ? VS_POL : ~VS_POL;
   assign RGB     = rgb_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a 15x8 clk toy raster (HD=8 VD=4, FB_LAT=1).
module tb_vga_scanout;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fb_req_o;
   logic [2:0]  fb_x_o;
   logic [1:0]  fb_y_o;
   logic [1:0]  fb_data_i = '0;
   logic        pal_we_i = 1'b0;
   logic [1:0]  pal_addr_i = '0;
   logic [11:0] pal_data_i = '0;
   logic        VGA_HS;
   logic        VGA_VS;
   logic        de_o;
   logic [11:0] RGB;
   logic        frame_o;
`ifdef VGA_TEST_PATTERN_EN
   logic        tp_en_i = 1'b0;
`endif

   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic        fr;
      logic [11:0] rgb;
   } out_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          mh, mv;
   bit          mtp;
   logic [11:0] mpal [4];
   out_t        q [3];
   int          cnt_hs, cnt_vs, cnt_de, cnt_fr;

   vga_scanout #(
      .HD(8), .HF(2), .HR(2), .HB(3),
      .VD(4), .VF(1), .VR(1), .VB(2),
      .HS_POL(1'b1), .VS_POL(1'b1),
      .BPP(2), .RGB_W(12), .FB_LAT(1)
   ) dut (
      .clk(clk),
      .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
      .tp_en_i(tp_en_i),
`endif
      .fb_req_o(fb_req_o),
      .fb_x_o(fb_x_o),
      .fb_y_o(fb_y_o),
      .fb_data_i(fb_data_i),
      .pal_we_i(pal_we_i),
      .pal_addr_i(pal_addr_i),
      .pal_data_i(pal_data_i),
      .VGA_HS(VGA_HS),
      .VGA_VS(VGA_VS),
      .de_o(de_o),
      .RGB(RGB),
      .frame_o(frame_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      mh = 0;
      mv = 0;
      mtp = 1'b0;
      mpal[0] = 12'h000;
      mpal[1] = 12'h000;
      mpal[2] = 12'h000;
      mpal[3] = 12'hFFF;
      for (int i = 0; i < 3; i++) q[i] = '0;
      cyc = 0;
   endtask

   // Checks the current cycle, advances the raster model and the frame-buffer responder by one clock.
   task automatic tick();
      bit         act;
      int         x;
      logic [1:0] idx;
      logic [1:0] nx;
      out_t       s;
      act = (mh >= 5) && (mh < 13) && (mv >= 3) && (mv < 7);
      x   = act ? mh - 5 : 0;
      chk("fb_req", {31'd0, fb_req_o}, {31'd0, act});
      chk("fb_x", {29'd0, fb_x_o}, x);
      chk("fb_y", {30'd0, fb_y_o}, act ? mv - 3 : 0);
      chk("de", {31'd0, de_o}, {31'd0, q[2].de});
      chk("hs", {31'd0, VGA_HS}, {31'd0, q[2].hs});
      chk("vs", {31'd0, VGA_VS}, {31'd0, q[2].vs});
      chk("frame", {31'd0, frame_o}, {31'd0, q[2].fr});
      chk("rgb", {20'd0, RGB}, {20'd0, q[2].rgb});
      cnt_hs += int'(VGA_HS);
      cnt_vs += int'(VGA_VS);
      cnt_de += int'(de_o);
      cnt_fr += int'(frame_o);
      idx   = mtp ? 2'((x >> 1) & 3) : 2'(x & 3);
      s.de  = act;
      s.hs  = (mh < 2);
      s.vs  = (mv < 1);
      s.fr  = act && (mh == 5) && (mv == 3);
      s.rgb = act ? mpal[idx] : 12'h000;
      q[2] = q[1];
      q[1] = q[0];
      q[0] = s;
`ifdef VGA_TEST_PATTERN_EN
      if (mh == 0 && mv == 0) mtp = tp_en_i;
`endif
      if (mh == 14) begin
         mh = 0;
         mv = (mv == 7) ? 0 : mv + 1;
      end else begin
         mh = mh + 1;
      end
      nx = fb_x_o[1:0];
      @(posedge clk);
      #1;
      fb_data_i = nx;
      cyc++;
   endtask

   task automatic run(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   task automatic pal_wr(input logic [1:0] a, input logic [11:0] d);
      pal_we_i   = 1'b1;
      pal_addr_i = a;
      pal_data_i = d;
      mpal[a]    = d;
      tick();
      pal_we_i   = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_de"}, {31'd0, de_o}, 32'd0);
      chk({tag, "_rgb"}, {20'd0, RGB}, 32'd0);
      chk({tag, "_frame"}, {31'd0, frame_o}, 32'd0);
      chk({tag, "_hs"}, {31'd0, VGA_HS}, 32'd0);
      chk({tag, "_vs"}, {31'd0, VGA_VS}, 32'd0);
      chk({tag, "_req"}, {31'd0, fb_req_o}, 32'd0);
   endtask

   initial begin
      // Power-on reset
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      chk_reset_outputs("reset");
      rst = 1'b0;

      // First frame with the reset palette
      run(50);
      chk("first_req", {31'd0, fb_req_o}, 32'd1);
      chk("first_x", {29'd0, fb_x_o}, 32'd0);
      chk("first_y", {30'd0, fb_y_o}, 32'd0);
      run(3);
      chk("first_frame", {31'd0, frame_o}, 32'd1);
      chk("first_de", {31'd0, de_o}, 32'd1);
      chk("first_rgb", {20'd0, RGB}, 32'h000);
      run(3);
      chk("rst_pal3", {20'd0, RGB}, 32'hFFF);

      // Program the palette during the vertical front porch
      run(54);
      pal_wr(2'd0, 12'h111);
      pal_wr(2'd1, 12'h222);
      pal_wr(2'd2, 12'h333);
      pal_wr(2'd3, 12'h444);
      run(9);
      cnt_hs = 0;
      cnt_vs = 0;
      cnt_de = 0;
      cnt_fr = 0;

      // Write entry 2 in the cycle that reads it for pixel x=2
      run(50);
      pal_wr(2'd2, 12'hF00);
      run(1);
      chk("same_cycle_old", {20'd0, RGB}, 32'h333);
      run(4);
      chk("after_write_new", {20'd0, RGB}, 32'hF00);
      run(64);
      chk("hs_per_frame", cnt_hs, 32'd16);
      chk("vs_per_frame", cnt_vs, 32'd15);
      chk("de_per_frame", cnt_de, 32'd32);
      chk("frame_per_frame", cnt_fr, 32'd1);
      run(52);
      chk("next_frame_new", {20'd0, RGB}, 32'hF00);

      // One-cycle reset in the middle of an active line
      run(2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      chk_reset_outputs("midrst");
      rst = 1'b0;
      run(53);
      chk("midrst_frame", {31'd0, frame_o}, 32'd1);
      chk("midrst_rgb0", {20'd0, RGB}, 32'h000);
      run(3);
      chk("midrst_pal3", {20'd0, RGB}, 32'hFFF);
      run(4);
`ifdef VGA_TEST_PATTERN_EN
      tp_en_i = 1'b1;
`endif
      run(26);
      chk("tp_not_yet", {20'd0, RGB}, 32'hFFF);
      run(14);
      pal_wr(2'd0, 12'h111);
      pal_wr(2'd1, 12'h222);
      pal_wr(2'd2, 12'h333);
      pal_wr(2'd3, 12'h444);
`ifdef VGA_TEST_PATTERN_EN
      run(71);
      chk("tp_bar1", {20'd0, RGB}, 32'h222);
      run(4);
      chk("tp_bar3", {20'd0, RGB}, 32'h444);
`else
      run(71);
      chk("fb_idx2", {20'd0, RGB}, 32'h333);
      run(4);
      chk("fb_idx2_b", {20'd0, RGB}, 32'h333);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
